// File: rtl/rob_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : rob_tag_allocator
// Description : Dual-issue ROB tag allocator and in-order retire sequencer.
//               Head/tail pointers plus an occupancy counter implement the ROB
//               as a circular queue. Up to two tags are handed out per cycle
//               to the dispatch slots, and up to two entries retire per cycle
//               in program order.
// Ports       : clk          - rising-edge clock
//               rst          - asynchronous, active-low reset
//               alloc1_req   - dispatch slot 1 needs a tag
//               alloc2_req   - dispatch slot 2 needs a tag
//               stall_in     - external stall, blocks allocation only
//               commit1      - oldest entry retires
//               commit2      - second-oldest also retires (only with commit1)
//               flush        - discard all in-flight entries
//               tag1/tag2    - tags offered to dispatch slots 1/2
//               commit1_tag  - head tag; commit2_tag - head+1 tag
//               alloc_stall  - requested tags exceed free entries
//               full/empty   - occupancy flags; count - in-flight entries
// Revision    : 1.0 - initial release
// ============================================================================
module rob_tag_allocator #(
    parameter int TAG_W = 5,
    parameter int DEPTH = 2**TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc1_req,
    input  logic             alloc2_req,
    input  logic             stall_in,
    input  logic             commit1,
    input  logic             commit2,
    input  logic             flush,
    output logic [TAG_W-1:0] tag1,
    output logic [TAG_W-1:0] tag2,
    output logic [TAG_W-1:0] commit1_tag,
    output logic [TAG_W-1:0] commit2_tag,
    output logic             alloc_stall,
    output logic             full,
    output logic             empty,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0]   c_DEPTH = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] c_ONE   = TAG_W'(1);

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic [TAG_W:0]   w_n_req;
    logic [TAG_W:0]   w_free;
    logic [TAG_W:0]   w_n_alloc;
    logic [TAG_W:0]   w_n_com;
    logic             w_stall;
    logic             w_grant;
    logic [TAG_W-1:0] w_head_adv;

    // Capacity is judged against the registered count only, so entries that
    // retire this cycle cannot be reused by this cycle's dispatch group.
    always_comb begin
        w_n_req   = (TAG_W+1)'(alloc1_req) + (TAG_W+1)'(alloc2_req);
        w_free    = c_DEPTH - r_count;
        w_stall   = !flush && (w_n_req > w_free);
        w_grant   = !flush && (w_n_req != '0) && !w_stall && !stall_in;
        w_n_alloc = w_grant ? w_n_req : '0;

        // Retire count clipped to occupancy; commit2 alone is ignored.
        w_n_com = '0;
        if (commit1 && (r_count != '0)) begin
            if (commit2 && (r_count > (TAG_W+1)'(1))) begin
                w_n_com = (TAG_W+1)'(2);
            end else begin
                w_n_com = (TAG_W+1)'(1);
            end
        end

        w_head_adv = r_head + w_n_com[TAG_W-1:0];
    end

    // Pointers wrap naturally since DEPTH == 2**TAG_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            // Commits in the flush cycle still retire; everything younger
            // is discarded by pulling tail back onto the new head.
            r_head  <= w_head_adv;
            r_tail  <= w_head_adv;
            r_count <= '0;
        end else begin
            r_head  <= w_head_adv;
            r_tail  <= r_tail + w_n_alloc[TAG_W-1:0];
            r_count <= r_count + w_n_alloc - w_n_com;
        end
    end

    // A lone slot-2 request takes the tail tag.
    assign tag1        = r_tail;
    assign tag2        = alloc1_req ? (r_tail + c_ONE) : r_tail;
    assign commit1_tag = r_head;
    assign commit2_tag = r_head + c_ONE;
    assign alloc_stall = w_stall;
    assign full        = (r_count == c_DEPTH);
    assign empty       = (r_count == '0);
    assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rob_tag_allocator.sv
`default_nettype none
// ============================================================================
// Module      : tb_rob_tag_allocator
// Description : Directed, table-driven bench for rob_tag_allocator with
//               hand-written sequences for fill, wrap, flush and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rob_tag_allocator;

    logic       clk;
    logic       rst;
    logic       alloc1_req;
    logic       alloc2_req;
    logic       stall_in;
    logic       commit1;
    logic       commit2;
    logic       flush;
    logic [4:0] tag1;
    logic [4:0] tag2;
    logic [4:0] commit1_tag;
    logic [4:0] commit2_tag;
    logic       alloc_stall;
    logic       full;
    logic       empty;
    logic [5:0] count;

    int n_vec;
    int n_miss;

    rob_tag_allocator #(.TAG_W(5), .DEPTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alloc1_req  (alloc1_req),
        .alloc2_req  (alloc2_req),
        .stall_in    (stall_in),
        .commit1     (commit1),
        .commit2     (commit2),
        .flush       (flush),
        .tag1        (tag1),
        .tag2        (tag2),
        .commit1_tag (commit1_tag),
        .commit2_tag (commit2_tag),
        .alloc_stall (alloc_stall),
        .full        (full),
        .empty       (empty),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a1, a2, st, c1, c2, fl;   // inputs
        int t1, t2, h1, h2, stl;      // expected combinational outputs
        int cnt;                      // expected count after the edge
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(input int a1, a2, st, c1, c2, fl,
                                input int t1, t2, h1, h2, stl, cnt);
        vec_t v;
        v.a1 = a1; v.a2 = a2; v.st = st; v.c1 = c1; v.c2 = c2; v.fl = fl;
        v.t1 = t1; v.t2 = t2; v.h1 = h1; v.h2 = h2; v.stl = stl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply inputs just after the falling edge, settle, count the vector.
    task automatic drive(input int a1, a2, st, c1, c2, fl);
        @(negedge clk);
        alloc1_req = a1[0];
        alloc2_req = a2[0];
        stall_in   = st[0];
        commit1    = c1[0];
        commit2    = c2[0];
        flush      = fl[0];
        #1;
        n_vec++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst = 1'b0;
        alloc1_req = 1'b0; alloc2_req = 1'b0; stall_in = 1'b0;
        commit1 = 1'b0; commit2 = 1'b0; flush = 1'b0;

        //            a1 a2 st c1 c2 fl   t1 t2 h1 h2 stl  cnt
        tbl[0]  = mk(1, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0,   2);
        tbl[1]  = mk(1, 1, 0, 0, 0, 0,   2, 3, 0, 1, 0,   4);
        tbl[2]  = mk(1, 1, 0, 0, 0, 0,   4, 5, 0, 1, 0,   6);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0,   6, 6, 0, 1, 0,   7);  // lone slot 2
        tbl[4]  = mk(1, 1, 1, 0, 0, 0,   7, 8, 0, 1, 0,   7);  // stall_in
        tbl[5]  = mk(0, 0, 0, 1, 0, 0,   7, 7, 0, 1, 0,   6);  // commit1
        tbl[6]  = mk(1, 0, 0, 1, 1, 0,   7, 8, 1, 2, 0,   5);  // commit2 + alloc1
        tbl[7]  = mk(0, 0, 0, 0, 1, 0,   8, 8, 3, 4, 0,   5);  // commit2 alone
        tbl[8]  = mk(1, 1, 0, 1, 0, 1,   8, 9, 3, 4, 0,   0);  // flush
        tbl[9]  = mk(0, 0, 0, 1, 1, 0,   4, 4, 4, 5, 0,   0);  // commit on empty
        tbl[10] = mk(1, 0, 0, 0, 0, 0,   4, 5, 4, 5, 0,   1);
        tbl[11] = mk(0, 0, 0, 1, 1, 0,   5, 5, 4, 5, 0,   0);  // pair commit, count 1

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk("reset_tag1", int'(tag1), 0);
        chk("reset_tag2", int'(tag2), 0);
        chk("reset_c1tag", int'(commit1_tag), 0);
        chk("reset_c2tag", int'(commit2_tag), 1);
        chk("reset_stall", int'(alloc_stall), 0);
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_full", int'(full), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a1, tbl[i].a2, tbl[i].st, tbl[i].c1, tbl[i].c2, tbl[i].fl);
            chk($sformatf("v%0d_tag1", i), int'(tag1), tbl[i].t1);
            chk($sformatf("v%0d_tag2", i), int'(tag2), tbl[i].t2);
            chk($sformatf("v%0d_c1tag", i), int'(commit1_tag), tbl[i].h1);
            chk($sformatf("v%0d_c2tag", i), int'(commit2_tag), tbl[i].h2);
            chk($sformatf("v%0d_stall", i), int'(alloc_stall), tbl[i].stl);
            tick();
            chk($sformatf("v%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("v%0d_empty", i), int'(empty), (tbl[i].cnt == 0) ? 1 : 0);
            chk($sformatf("v%0d_full", i), int'(full), (tbl[i].cnt == 32) ? 1 : 0);
        end

        // Async reset pulsed mid-cycle from head = tail = 5
        n_vec++;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_tag1", int'(tag1), 0);
        chk("arst_c1tag", int'(commit1_tag), 0);
        chk("arst_c2tag", int'(commit2_tag), 1);
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        @(negedge clk);
        alloc1_req = 1'b0; alloc2_req = 1'b0; stall_in = 1'b0;
        commit1 = 1'b0; commit2 = 1'b0; flush = 1'b0;
        rst = 1'b1;

        // Fill to 31
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            chk($sformatf("fill%0d_tag1", i), int'(tag1), 2*i);
            tick();
            chk($sformatf("fill%0d_count", i), int'(count), 2*i + 2);
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("fill_last_tag1", int'(tag1), 30);
        tick();
        chk("c31_count", int'(count), 31);
        chk("c31_full", int'(full), 0);

        // One free entry, pair request: denied, tags still shown wrapping
        drive(1, 1, 0, 0, 0, 0);
        chk("c31_pair_stall", int'(alloc_stall), 1);
        chk("c31_pair_tag1", int'(tag1), 31);
        chk("c31_pair_tag2", int'(tag2), 0);
        tick();
        chk("c31_pair_count", int'(count), 31);

        drive(1, 0, 0, 0, 0, 0);
        chk("c31_single_stall", int'(alloc_stall), 0);
        chk("c31_single_tag1", int'(tag1), 31);
        tick();
        chk("full_count", int'(count), 32);
        chk("full_flag", int'(full), 1);
        chk("full_empty", int'(empty), 0);

        // Full: commit pair plus alloc pair in the same cycle
        drive(1, 1, 0, 1, 1, 0);
        chk("full_cc_stall", int'(alloc_stall), 1);
        chk("full_cc_c1tag", int'(commit1_tag), 0);
        tick();
        chk("full_cc_count", int'(count), 30);
        chk("full_cc_head", int'(commit1_tag), 2);

        drive(1, 1, 0, 0, 0, 0);
        chk("regrant_stall", int'(alloc_stall), 0);
        chk("regrant_tag1", int'(tag1), 0);
        chk("regrant_tag2", int'(tag2), 1);
        tick();
        chk("regrant_count", int'(count), 32);
        chk("regrant_full", int'(full), 1);

        // Drain to wrap head 31 -> 0
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, 0, 1, 1, 0);
            chk($sformatf("drain%0d_c1tag", i), int'(commit1_tag), 2 + 2*i);
            tick();
            chk($sformatf("drain%0d_count", i), int'(count), 30 - 2*i);
        end
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("wrap_count", int'(count), 3);
        chk("wrap_c1tag", int'(commit1_tag), 31);
        chk("wrap_c2tag", int'(commit2_tag), 0);
        drive(0, 0, 0, 1, 1, 0);
        tick();
        chk("wrapped_count", int'(count), 1);
        chk("wrapped_c1tag", int'(commit1_tag), 1);

        // commit2 alone on a non-empty ROB
        drive(0, 0, 0, 0, 1, 0);
        tick();
        chk("c2only_count", int'(count), 1);
        chk("c2only_c1tag", int'(commit1_tag), 1);
        drive(0, 0, 0, 1, 0, 0);
        tick();
        chk("drain_empty", int'(empty), 1);

        // Build count = 10, head = 4 (tail = 14)
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 1, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        chk("preflush_count", int'(count), 10);
        chk("preflush_c1tag", int'(commit1_tag), 4);
        chk("preflush_tail", int'(tag1), 14);

        // Flush with commit1 and an alloc pair
        drive(1, 1, 0, 1, 0, 1);
        chk("flush_stall", int'(alloc_stall), 0);
        tick();
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_head", int'(commit1_tag), 5);
        chk("flush_tail", int'(tag1), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
